// File: rtl/mul_share_ctrl.sv
// Sequencer and arbiter that shares one 58x58 mantissa multiplier tree between the
// FP multiply path (port 0) and the divide/sqrt path (port 1). Define MUL_SHARE_RR_EN for round-robin ties.
module mul_share_ctrl #(
    parameter int unsigned MC_CYCLES = 2,
    parameter int unsigned W         = 58
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [2*W-1:0]   rsp_product,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MC_CYCLES - 1);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             id_q;
    logic [2*W-1:0]   prod_q;
    logic             rsp_id_q;
    logic             rsp_valid_q;
    logic             busy_q;
    logic             last_id_q;

    logic             gnt0_s;
    logic             gnt1_s;
    logic [2*W-1:0]   tree_prod_s;

    // Shared multiplier tree: fed only from the latched operands so port activity cannot disturb it.
    assign tree_prod_s = (2*W)'(a_q) * (2*W)'(b_q);

`ifndef MUL_SHARE_RR_EN
    // Fixed priority ignores the last winner; it is still tracked so both builds share one datapath.
    logic unused_last_id_s;
    assign unused_last_id_s = last_id_q;
`endif

    // Grant selection: only in IDLE, never while reset is asserted, at most one winner.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (state_q == IDLE && !reset) begin
`ifdef MUL_SHARE_RR_EN
            if (req0_valid && req1_valid) begin
                gnt0_s = last_id_q;
                gnt1_s = ~last_id_q;
            end else begin
                gnt0_s = req0_valid;
                gnt1_s = req1_valid;
            end
`else
            if (req0_valid) begin
                gnt0_s = 1'b1;
            end else begin
                gnt1_s = req1_valid;
            end
`endif
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign req0_ready  = gnt0_s;
    assign req1_ready  = gnt1_s;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = prod_q;
    assign busy        = busy_q;

    // Control FSM with operand latch, evaluation counter and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            prod_q      <= '0;
            rsp_id_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            last_id_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0_s || gnt1_s) begin
                        a_q     <= gnt1_s ? req1_a : req0_a;
                        b_q     <= gnt1_s ? req1_b : req0_b;
                        id_q    <= gnt1_s;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        prod_q      <= tree_prod_s;
                        rsp_id_q    <= id_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // Returning to IDLE here means the next request is granted one cycle later.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        last_id_q   <= rsp_id_q;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= 4'd0;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl: directed requests push expected responses,
// a monitor pops and compares on every response handshake.
module tb_mul_share_ctrl;

    localparam int unsigned MC = 2;
    localparam int unsigned W  = 58;

    typedef struct packed {
        logic           id;
        logic [2*W-1:0] prod;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             req0_valid, req0_ready;
    logic [W-1:0]     req0_a, req0_b;
    logic             req1_valid, req1_ready;
    logic [W-1:0]     req1_a, req1_b;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [2*W-1:0]   rsp_product;
    logic             busy;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    mul_share_ctrl #(.MC_CYCLES(MC), .W(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_product(rsp_product), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every response handshake is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: got id=%0d product=0x%0h, expected none", rsp_id, rsp_product);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", 128'(rsp_id), 128'(e.id));
                chk("rsp_product", 128'(rsp_product), 128'(e.prod));
            end
        end
    end

    task automatic push(input logic id, input logic [2*W-1:0] prod);
        exp_t e;
        e.id   = id;
        e.prod = prod;
        exp_q.push_back(e);
    endtask

    // Present a request and hold it until accepted; returns 1ns after the accept edge.
    task automatic issue(input logic port, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        if (port) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if ((port ? req1_ready : req0_ready) == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!ok) chk("accept_timeout", 128'(0), 128'(1));
    endtask

    // Count negedges after the accept edge until rsp_valid is seen.
    task automatic check_latency(input string name);
        int lat;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) chk("busy_after_accept", 128'(busy), 128'(1));
            if (rsp_valid) break;
            lat++;
        end
        chk(name, 128'(lat), 128'(MC));
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk("drain", 128'(exp_q.size()), 128'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [2*W-1:0] maxp;
        int acc;
        maxp = 116'd0 - (116'd1 << 59) + 116'd1;

        reset = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        repeat (2) @(negedge clk);
        req0_valid = 1'b1;
        #1;
        chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("reset_rsp_product", 128'(rsp_product), 128'(0));
        chk("reset_rsp_id", 128'(rsp_id), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_readys", 128'({req0_ready, req1_ready}), 128'(0));
        req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Single request: 3*5
        push(1'b0, 116'd15);
        issue(1'b0, 58'd3, 58'd5);
        check_latency("latency_3x5");
        drain();

        // Full-scale operands on port 1
        push(1'b1, maxp);
        issue(1'b1, {W{1'b1}}, {W{1'b1}});
        drain();

        // Simultaneous valids held for three accepts
`ifdef MUL_SHARE_RR_EN
        push(1'b0, 116'd14); push(1'b1, 116'd16); push(1'b0, 116'd14);
`else
        push(1'b0, 116'd14); push(1'b0, 116'd14); push(1'b0, 116'd14);
`endif
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 58'd2; req0_b = 58'd7;
        req1_valid = 1'b1; req1_a = 58'd4; req1_b = 58'd4;
        acc = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                chk("single_grant", 128'(req0_ready & req1_ready), 128'(0));
                acc++;
                if (acc == 3) begin
                    @(posedge clk); #1;
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                    break;
                end
            end
        end
        chk("tie_accepts", 128'(acc), 128'(3));
        drain();

        // Backpressure: stall in DONE with both requesters waiting
        rsp_ready = 1'b0;
        push(1'b1, 116'd143);
        issue(1'b1, 58'd11, 58'd13);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        req0_valid = 1'b1; req0_a = 58'd6; req0_b = 58'd7;
        req1_valid = 1'b1; req1_a = 58'd1; req1_b = 58'd1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 128'(rsp_valid), 128'(1));
            chk("stall_product", 128'(rsp_product), 128'(143));
            chk("stall_id", 128'(rsp_id), 128'(1));
            chk("stall_readys", 128'({req0_ready, req1_ready}), 128'(0));
        end
        push(1'b0, 116'd42);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_readys_done", 128'({req0_ready, req1_ready}), 128'(0));
        @(negedge clk);
        chk("release_idle_busy", 128'(busy), 128'(0));
        chk("release_grant", 128'({req0_ready, req1_ready}), 128'(2));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // Port operands change during CALC
        push(1'b0, 116'd81);
        issue(1'b0, 58'd9, 58'd9);
        req0_a = 58'd1; req0_b = 58'd1;
        drain();

        // Reset in CALC discards the in-flight product
        issue(1'b0, 58'd6, 58'd6);
        req0_valid = 1'b1;
        reset = 1'b1;
        #1;
        chk("midcalc_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("midcalc_busy", 128'(busy), 128'(0));
        chk("midcalc_product", 128'(rsp_product), 128'(0));
        chk("midcalc_id", 128'(rsp_id), 128'(0));
        chk("midcalc_readys", 128'({req0_ready, req1_ready}), 128'(0));
        req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_rsp_after_reset", 128'(rsp_valid), 128'(0));
        push(1'b0, 116'd4);
        issue(1'b0, 58'd2, 58'd2);
        check_latency("latency_2x2");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
